// File: rtl/btn_press_classifier.sv
// Groups button press pulses falling inside a time window into single/double
// (and, with BTN_PRESS_TRIPLE_EN defined, triple) press events.
module btn_press_classifier #(
  parameter int WINDOW_CYC = 50000000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sign,
  output logic       single_evt,
  output logic       double_evt,
  output logic       triple_evt,
  output logic       busy,
  output logic [7:0] evt_count
);

`ifdef BTN_PRESS_TRIPLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT1 = 2'd1, WAIT2 = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, WAIT1 = 1'b1} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(WINDOW_CYC - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic             sign_d;
  logic             press;
  logic             expire;
  logic             single_next;
  logic             double_next;
  logic             triple_next;
  logic             any_next;

  assign press  = sign & ~sign_d;
  assign expire = (timer == LAST_TICK);

  // NOTE: state flops use non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      sign_d <= 1'b0;
    end else begin
      state  <= next_state;
      timer  <= timer_next;
      sign_d <= sign;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch forms.
  always_comb begin
    next_state = state;
    timer_next = '0;
    case (state)
      IDLE: begin
        if (press) next_state = WAIT1;
      end
      WAIT1: begin
        if (press) begin
`ifdef BTN_PRESS_TRIPLE_EN
          next_state = WAIT2;
`else
          next_state = IDLE;
`endif
        end else if (expire) begin
          next_state = IDLE;
        end else begin
          timer_next = timer + CNT_W'(1);
        end
      end
`ifdef BTN_PRESS_TRIPLE_EN
      WAIT2: begin
        if (press || expire) next_state = IDLE;
        else                 timer_next = timer + CNT_W'(1);
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // A press arriving on the expiry tick takes priority: it joins the group.
  always_comb begin
    single_next = (state == WAIT1) && !press && expire;
`ifdef BTN_PRESS_TRIPLE_EN
    double_next = (state == WAIT2) && !press && expire;
    triple_next = (state == WAIT2) && press;
`else
    double_next = (state == WAIT1) && press;
    triple_next = 1'b0;
`endif
    any_next = single_next | double_next | triple_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_evt <= 1'b0;
      double_evt <= 1'b0;
      busy       <= 1'b0;
      evt_count  <= 8'd0;
    end else begin
      single_evt <= single_next;
      double_evt <= double_next;
      busy       <= (next_state != IDLE);
      if (any_next && (evt_count != 8'hFF)) evt_count <= evt_count + 8'd1;
    end
  end

`ifdef BTN_PRESS_TRIPLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) triple_evt <= 1'b0;
    else        triple_evt <= triple_next;
  end
`else
  assign triple_evt = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_classifier.sv
// Self-checking bench for btn_press_classifier with WINDOW_CYC=8; expected
// events come from a press-grouping model working on lists of edge times.
module tb_btn_press_classifier;
  localparam int W    = 8;
  localparam int MAXC = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sign = 1'b0;
  logic       single_evt, double_evt, triple_evt, busy;
  logic [7:0] evt_count;

  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;

  logic        wave   [MAXC];
  logic [11:0] exp_v  [MAXC];
  logic [11:0] obs_v  [MAXC];
  int          ev_kind[MAXC];
  bit          bz     [MAXC];

  btn_press_classifier #(.WINDOW_CYC(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sign(sign),
    .single_evt(single_evt), .double_evt(double_evt), .triple_evt(triple_evt),
    .busy(busy), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  task automatic clear_wave();
    for (int i = 0; i < MAXC; i++) wave[i] = 1'b0;
  endtask

  task automatic pulse(input int at, input int len);
    for (int i = at; i < at + len; i++) wave[i] = 1'b1;
  endtask

  // Model: list press edges, then group them by distance (<= W joins the group).
  task automatic build_expected(input int len);
    int q[$];
    int idx, s, t1, t2, ev_at, kind;
    for (int c = 0; c < MAXC; c++) begin ev_kind[c] = -1; bz[c] = 1'b0; end
    for (int c = 0; c < len; c++)
      if (wave[c] && (c == 0 || !wave[c-1])) q.push_back(c);
    idx = 0;
    while (idx < q.size()) begin
      s = q[idx]; idx++;
      if (idx < q.size() && q[idx] - s <= W) begin
        t1 = q[idx]; idx++;
`ifdef BTN_PRESS_TRIPLE_EN
        if (idx < q.size() && q[idx] - t1 <= W) begin
          t2 = q[idx]; idx++;
          kind = 2; ev_at = t2 + 1;
        end else begin
          kind = 1; ev_at = t1 + W + 1;
        end
`else
        kind = 1; ev_at = t1 + 1;
`endif
      end else begin
        kind = 0; ev_at = s + W + 1;
      end
      if (ev_at < MAXC) ev_kind[ev_at] = kind;
      for (int b = s + 1; b < ev_at && b < MAXC; b++) bz[b] = 1'b1;
    end
    for (int c = 0; c < len; c++) begin
      if (ev_kind[c] >= 0 && model_cnt < 255) model_cnt++;
      exp_v[c] = {ev_kind[c] == 0, ev_kind[c] == 1, ev_kind[c] == 2, bz[c], 8'(model_cnt)};
    end
  endtask

  // Cycle c: outputs sampled mid-cycle, then sign for cycle c is applied.
  task automatic run_wave(input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      obs_v[c] = {single_evt, double_evt, triple_evt, busy, evt_count};
      sign = wave[c];
    end
    sign = 1'b0;
  endtask

  task automatic test_reset_initial();
    #1;
    n_checks++;
    if ({single_evt, double_evt, triple_evt, busy, evt_count} !== 12'd0)
      $display("FAIL reset_initial: got s/d/t/b=%b%b%b%b cnt=%0d, expected all 0",
               single_evt, double_evt, triple_evt, busy, evt_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_single();
    int nf = 0;
    clear_wave(); pulse(10, 1);
    build_expected(40); run_wave(40);
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL single c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
    n_checks++;
    if (obs_v[19][11] !== 1'b1 || obs_v[18][8] !== 1'b1 || obs_v[19][8] !== 1'b0)
      $display("FAIL single_latency: got single@19=%b busy@18=%b busy@19=%b, expected 1 1 0",
               obs_v[19][11], obs_v[18][8], obs_v[19][8]);
    else n_pass++;
  endtask

  task automatic test_double();
    int nf = 0;
    int at;
    clear_wave(); pulse(10, 1); pulse(14, 1);
    build_expected(40); run_wave(40);
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL double c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
`ifdef BTN_PRESS_TRIPLE_EN
    at = 23;
`else
    at = 15;
`endif
    n_checks++;
    if (obs_v[at][10] !== 1'b1)
      $display("FAIL double_latency: got double@%0d=%b, expected 1", at, obs_v[at][10]);
    else n_pass++;
  endtask

  task automatic test_held();
    int nf = 0;
    clear_wave(); pulse(10, 21);
    build_expected(50); run_wave(50);
    for (int c = 0; c < 50; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL held c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_collision();
    int nf = 0;
    clear_wave(); pulse(10, 1); pulse(18, 1);
    build_expected(45); run_wave(45);
    for (int c = 0; c < 45; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL collision c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int nf = 0;
    clear_wave(); pulse(10, 1); pulse(19, 1); pulse(37, 1); pulse(41, 1); pulse(42 + W, 1);
    build_expected(80); run_wave(80);
    for (int c = 0; c < 80; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL back_to_back c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_triple_pattern();
    int nf = 0;
    clear_wave(); pulse(10, 1); pulse(12, 1); pulse(14, 1);
    build_expected(45); run_wave(45);
    for (int c = 0; c < 45; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL triple_pattern c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int nf = 0;
    @(negedge clk); sign = 1'b1;
    @(negedge clk); sign = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy: got busy=%b, expected 1", busy);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({single_evt, double_evt, triple_evt, busy, evt_count} !== 12'd0)
      $display("FAIL reset_mid: got s/d/t/b=%b%b%b%b cnt=%0d, expected all 0",
               single_evt, double_evt, triple_evt, busy, evt_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    clear_wave(); pulse(5, 1);
    build_expected(30); run_wave(30);
    for (int c = 0; c < 30; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL reset_mid_after c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
    n_checks++;
    if (obs_v[14][11] !== 1'b1 || obs_v[14][7:0] !== 8'd1)
      $display("FAIL reset_mid_single: got single@14=%b cnt=%0d, expected 1 1",
               obs_v[14][11], obs_v[14][7:0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int nf = 0;
      int c = 2;
      clear_wave();
      while (c < 580) begin
        int hi = $urandom_range(1, 4);
        pulse(c, hi);
        c += hi + 1 + $urandom_range(0, 12);
      end
      build_expected(600); run_wave(600);
      for (int k = 0; k < 600; k++) begin
        n_checks++;
        if (obs_v[k] !== exp_v[k]) begin
          if (nf++ < 4) $display("FAIL random%0d c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                                 it, k, obs_v[k][11:8], obs_v[k][7:0], exp_v[k][11:8], exp_v[k][7:0]);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    int nf = 0;
    clear_wave();
    for (int k = 0; k < 300; k++) pulse(5 + 10 * k, 1);
    build_expected(3020); run_wave(3020);
    for (int c = 0; c < 3020; c++) begin
      n_checks++;
      if (obs_v[c] !== exp_v[c]) begin
        if (nf++ < 4) $display("FAIL saturation c=%0d: got sdtb=%b cnt=%0d, expected sdtb=%b cnt=%0d",
                               c, obs_v[c][11:8], obs_v[c][7:0], exp_v[c][11:8], exp_v[c][7:0]);
      end else n_pass++;
    end
    n_checks++;
    if (evt_count !== 8'd255) $display("FAIL saturation_final: got cnt=%0d, expected 255", evt_count);
    else n_pass++;
  endtask

  initial begin
    test_reset_initial();
    test_single();
    test_double();
    test_held();
    test_collision();
    test_back_to_back();
    test_triple_pattern();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
